// File: rtl/reg_pipe.sv
// ============================================================================
// reg_pipe : DEPTH-stage valid/ready register pipeline with flush and count
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_pipe #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [DEPTH-1:0][W-1:0] d;
  logic [DEPTH-1:0]        v;
  logic [DEPTH-1:0]        adv;
  logic [DEPTH-1:0]        fill;
  logic [DEPTH-1:0]        v_nxt;
  logic                    room;
  logic                    in_xfer;
  logic                    out_xfer;

  // Walk from the output back to the input: each stage may move when the
  // stage after it is empty or itself moving, so bubbles are squeezed out.
  always_comb begin
    adv   = '0;
    fill  = '0;
    v_nxt = '0;
    room  = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k] = v[k] & room;
      room   = ~v[k] | adv[k];
    end
    in_ready  = ~clr & room;
    in_xfer   = in_valid & in_ready;
    out_valid = v[DEPTH-1] & ~clr;
    out_xfer  = out_valid & out_ready;
    fill[0]   = in_xfer;
    for (int k = 1; k < DEPTH; k++) begin
      fill[k] = adv[k-1];
    end
    v_nxt = fill | (v & ~adv);
  end

  assign out_data = d[DEPTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d     <= '0;
      v     <= '0;
      count <= '0;
    end else if (clr) begin
      v     <= '0;
      count <= '0;
    end else begin
      v <= v_nxt;
      if (in_xfer) begin
        d[0] <= in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k-1]) begin
          d[k] <= d[k-1];
        end
      end
      if (in_xfer && !out_xfer) begin
        count <= count + CNT_ONE;
      end else if (out_xfer && !in_xfer) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_pipe.sv
// ============================================================================
// tb_reg_pipe : directed + random bench for reg_pipe against a conveyor model
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_reg_pipe;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 5;

  logic          clk;
  logic          clk_en;
  logic          rst_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  int n_assert;
  int n_fail;

  reg_pipe #(.W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words ride a conveyor of DEPTH slots, oldest first; each word moves
  // one slot per cycle unless the slot ahead is occupied by a word that stays.
  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } ent_t;

  ent_t q[$];

  function automatic logic [DEPTH-1:0] moves(input logic ordy);
    logic [DEPTH-1:0] m;
    m = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) m[i] = (q[0].pos == DEPTH - 1) ? ordy : 1'b1;
      else        m[i] = (q[i-1].pos != q[i].pos + 1) || m[i-1];
    end
    return m;
  endfunction

  function automatic logic exp_in_ready(input logic [DEPTH-1:0] m);
    if (clr) return 1'b0;
    if (q.size() == 0) return 1'b1;
    return (q[q.size()-1].pos != 0) || m[q.size()-1];
  endfunction

  function automatic logic exp_out_valid();
    return !clr && (q.size() > 0) && (q[0].pos == DEPTH - 1);
  endfunction

  task automatic model_step();
    logic [DEPTH-1:0] m;
    logic             ir;
    logic             lv;
    ent_t             e;
    if (!rst_n || clr) begin
      q.delete();
      return;
    end
    m  = moves(out_ready);
    ir = exp_in_ready(m);
    lv = (q.size() > 0) && (q[0].pos == DEPTH - 1) && out_ready;
    for (int i = 0; i < q.size(); i++) begin
      if (m[i] && !(i == 0 && lv)) q[i].pos = q[i].pos + 1;
    end
    if (lv) void'(q.pop_front());
    if (in_valid && ir) begin
      e.data = in_data;
      e.pos  = 0;
      q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge rst_n);
    q.delete();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'(!clr));
    end else begin
      chk("mdl_in_ready", 32'(in_ready), 32'(exp_in_ready(moves(out_ready))));
      chk("mdl_out_valid", 32'(out_valid), 32'(exp_out_valid()));
      chk("mdl_count", 32'(count), 32'(q.size()));
      if (exp_out_valid()) chk("mdl_out_data", 32'(out_data), 32'(q[0].data));
    end
  end

  logic [W-1:0] rx[$];
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) rx.push_back(out_data);
  end

  int exp_cnt[12];
  int idx;
  logic acc;

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    clk_en    = 1'b0;
    rst_n     = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;

    // Asynchronous reset with no clock running.
    #3 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", 32'(out_data), 32'h0000);
    chk("reset_count", 32'(count), 32'd0);
    #5 rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    clk_en = 1'b1;
    @(posedge clk);
    #1;

    // Streaming 0x0001..0x0008 with out_ready held high.
    exp_cnt = '{1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
    for (int c = 0; c < 12; c++) begin
      in_valid  = (c < 8);
      in_data   = 16'(c + 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stream_count", 32'(count), 32'(exp_cnt[c]));
      chk("stream_out_valid", 32'(out_valid), 32'(c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) chk("stream_out_data", 32'(out_data), 32'(c - 2));
    end

    // Backpressure: fill with out_ready low, then release.
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rx.delete();
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0011 + idx);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd4);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_in_ready_full", 32'(in_ready), 32'd0);
    in_data   = 16'(16'h0011 + idx);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 32'd1);
    for (int c = 0; c < 12 && idx < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0011 + idx);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("bp_rx_size", 32'(rx.size()), 32'd8);
    for (int i = 0; i < rx.size() && i < 8; i++) begin
      chk("bp_rx_order", 32'(rx[i]), 32'(16'h0011 + i));
    end

    // Flush with three words held.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0021 + c);
      @(posedge clk);
      #1;
    end
    chk("flush_pre_count", 32'(count), 32'd3);
    clr       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h00AA;
    out_ready = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("flush_count", 32'(count), 32'd0);
    clr     = 1'b0;
    in_data = 16'h00BB;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("flush_latency", 32'(out_valid), 32'(e == 3));
      if (e == 3) chk("flush_next_data", 32'(out_data), 32'h00BB);
    end
    @(posedge clk);
    #1;

    // Reset dropped between edges with two words held.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h0031 + c);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("midrst_pre_count", 32'(count), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'h0000);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      clr       = ($urandom_range(0, 15) == 0);
      in_data   = 16'($urandom);
    end
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
